// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one multi-cycle fp32 adder between NREQ requesters.
// The adder request is held until its done pulse; a watchdog aborts a stuck operation with a quiet NaN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no operation; grant first requester at/after ptr, latch operands
// S_ISSUE | raise add_start, clear watchdog
// S_WAIT  | add_start held; wait for add_done or watchdog expiry
// S_RESP  | done/err pulse visible, advance round-robin pointer
module fp_add_arbiter #(
   parameter int NREQ    = 2,
   parameter int IDXW    = 1,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [32*NREQ-1:0]   a_in,
   input  logic [32*NREQ-1:0]   b_in,
   output logic [NREQ-1:0]      done,
   output logic                 err,
   output logic [31:0]          res_out,
   output logic                 busy,
   output logic [IDXW-1:0]      gnt_idx,
   output logic [31:0]          add_a,
   output logic [31:0]          add_b,
   output logic                 add_start,
   input  logic [31:0]          add_res,
   input  logic                 add_done
);

   localparam int              WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);
   localparam logic [IDXW-1:0] IDX_MAX = IDXW'(NREQ - 1);
   localparam logic [31:0]     QNAN    = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            state;
   logic [IDXW-1:0]   ptr;
   logic [WDW-1:0]    wd_cnt;

   logic              pick_hit;
   logic [IDXW-1:0]   pick_idx;
   logic [31:0]       pick_a;
   logic [31:0]       pick_b;
   logic [NREQ-1:0]   gnt_onehot;
   logic [IDXW-1:0]   ptr_nxt;

   // Two passes give "first set bit at or after ptr, wrapping" without a rotator.
   always_comb begin
      pick_hit = 1'b0;
      pick_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!pick_hit && req[i] && (IDXW'(i) >= ptr)) begin
            pick_hit = 1'b1;
            pick_idx = IDXW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!pick_hit && req[i]) begin
            pick_hit = 1'b1;
            pick_idx = IDXW'(i);
         end
      end
   end

   always_comb begin
      pick_a = '0;
      pick_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (IDXW'(i) == pick_idx) begin
            pick_a = a_in[32*i +: 32];
            pick_b = b_in[32*i +: 32];
         end
      end
   end

   always_comb begin
      gnt_onehot = '0;
      for (int i = 0; i < NREQ; i++) begin
         gnt_onehot[i] = (IDXW'(i) == gnt_idx);
      end
   end

   assign ptr_nxt = (gnt_idx == IDX_MAX) ? '0 : gnt_idx + IDXW'(1);

   // done/err are loaded on the WAIT->RESP edge so they are high exactly during RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         ptr       <= '0;
         wd_cnt    <= '0;
         done      <= '0;
         err       <= 1'b0;
         res_out   <= '0;
         busy      <= 1'b0;
         gnt_idx   <= '0;
         add_a     <= '0;
         add_b     <= '0;
         add_start <= 1'b0;
      end else begin
         done <= '0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_hit) begin
                  gnt_idx <= pick_idx;
                  add_a   <= pick_a;
                  add_b   <= pick_b;
                  busy    <= 1'b1;
                  state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               add_start <= 1'b1;
               wd_cnt    <= '0;
               state     <= S_WAIT;
            end
            S_WAIT: begin
               if (add_done) begin
                  res_out   <= add_res;
                  add_start <= 1'b0;
                  done      <= gnt_onehot;
                  state     <= S_RESP;
               end else if (wd_cnt == WD_LAST) begin
                  res_out   <= QNAN;
                  err       <= 1'b1;
                  add_start <= 1'b0;
                  done      <= gnt_onehot;
                  state     <= S_RESP;
               end else begin
                  wd_cnt <= wd_cnt + WDW'(1);
               end
            end
            S_RESP: begin
               ptr   <= ptr_nxt;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               add_start <= 1'b0;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed and randomized bench for fp_add_arbiter with a behavioural fp32 adder
// and a round-robin / real-arithmetic reference model.
module tb_fp_add_arbiter;

   localparam int NREQ    = 2;
   localparam int IDXW    = 1;
   localparam int TIMEOUT = 16;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [32*NREQ-1:0] a_in;
   logic [32*NREQ-1:0] b_in;
   logic [NREQ-1:0]   done;
   logic              err;
   logic [31:0]       res_out;
   logic              busy;
   logic [IDXW-1:0]   gnt_idx;
   logic [31:0]       add_a;
   logic [31:0]       add_b;
   logic              add_start;
   logic [31:0]       add_res;
   logic              add_done;

   logic              mdl_done;
   logic              inj_done;
   bit                adder_on;
   bit                abusy;
   int                lat;
   int                cnt;

   int                checks;
   int                errors;
   int                rr_ptr;
   logic [31:0]       opa [NREQ];
   logic [31:0]       opb [NREQ];

   fp_add_arbiter #(.NREQ(NREQ), .IDXW(IDXW), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .done      (done),
      .err       (err),
      .res_out   (res_out),
      .busy      (busy),
      .gnt_idx   (gnt_idx),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_start (add_start),
      .add_res   (add_res),
      .add_done  (add_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:0] == 31'd0) return 0.0;
      d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [10:0] e;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] int2f(input int v);
      return r2f(real'(v));
   endfunction

   function automatic logic [31:0] rnd_f();
      int v;
      v = int'($urandom_range(0, 200)) - 100;
      return int2f(v);
   endfunction

   // Behavioural adder: fixed latency from the sampled request, one-cycle done pulse.
   always @(posedge clk) begin
      mdl_done <= 1'b0;
      if (rst) begin
         abusy <= 1'b0;
      end else if (abusy) begin
         if (cnt <= 1) begin
            mdl_done <= 1'b1;
            add_res  <= r2f(f2r(add_a) + f2r(add_b));
            abusy    <= 1'b0;
         end else begin
            cnt <= cnt - 1;
         end
      end else if (add_start && !mdl_done && adder_on) begin
         abusy <= 1'b1;
         cnt   <= lat;
      end
   end

   assign add_done = mdl_done | inj_done;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int next_grant(input logic [NREQ-1:0] r);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(rr_ptr + k) % NREQ]) return (rr_ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
      opa[i] = a;
      opb[i] = b;
      if (i == 0) begin
         a_in[31:0] = a;
         b_in[31:0] = b;
      end else begin
         a_in[63:32] = a;
         b_in[63:32] = b;
      end
   endtask

   task automatic wait_start(input string tag);
      for (int n = 0; n < 60 && add_start !== 1'b1; n++) tick();
      chk({tag, "_start_seen"}, add_start, 1);
   endtask

   // Waits for the done pulse of requester idx and checks result, timing and pulse width.
   task automatic serve(input int idx, input logic [31:0] exp_res, input bit drop, input string tag);
      logic [NREQ-1:0] exp_done;
      logic            last_ad;
      exp_done = NREQ'(1) << idx;
      last_ad  = 1'b0;
      for (int n = 0; n < 400; n++) begin
         tick();
         if (last_ad) chk({tag, "_start_drop"}, add_start, 0);
         if (done != '0) break;
         last_ad = add_done;
      end
      chk({tag, "_done"}, done, exp_done);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_res"}, res_out, exp_res);
      chk({tag, "_gnt"}, gnt_idx, idx);
      chk({tag, "_ad_to_done"}, last_ad, 1);
      rr_ptr = (idx + 1) % NREQ;
      if (drop) req[idx] = 1'b0;
      tick();
      chk({tag, "_pulse"}, done, 0);
   endtask

   initial begin
      int g;
      int k;
      int p;
      logic [31:0] x;
      logic [31:0] y;
      checks = 0; errors = 0; rr_ptr = 0;
      rst = 1'b1; req = '0; a_in = '0; b_in = '0;
      adder_on = 1'b1; lat = 7; inj_done = 1'b0; add_res = '0;
      for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_res", res_out, 0);
      chk("rst_gnt", gnt_idx, 0);
      chk("rst_add_a", add_a, 0);
      chk("rst_add_b", add_b, 0);
      chk("rst_start", add_start, 0);
      rst = 1'b0;
      tick();

      // single request, exact latency into the adder
      set_ops(0, 32'h3F80_0000, 32'h4000_0000);
      req = 2'b01;
      tick();
      chk("t1_issue_start", add_start, 0);
      chk("t1_busy", busy, 1);
      tick();
      chk("t1_start", add_start, 1);
      chk("t1_add_a", add_a, 32'h3F80_0000);
      chk("t1_add_b", add_b, 32'h4000_0000);
      serve(0, 32'h4040_0000, 1'b1, "t1");

      // mixed sign on requester 1
      set_ops(1, 32'h4040_0000, 32'hBF80_0000);
      req = 2'b10;
      g = next_grant(req);
      serve(g, 32'h4000_0000, 1'b1, "t2");

      // both requesting continuously: alternation
      set_ops(0, rnd_f(), rnd_f());
      set_ops(1, rnd_f(), rnd_f());
      req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         g = next_grant(req);
         serve(g, r2f(f2r(opa[g]) + f2r(opb[g])), 1'b0, "t3");
         set_ops(g, rnd_f(), rnd_f());
      end
      req = '0;
      tick();

      // randomized request patterns, operands and adder latency
      for (int it = 0; it < 12; it++) begin
         p   = int'($urandom_range(1, 3));
         lat = int'($urandom_range(1, 9));
         for (int i = 0; i < NREQ; i++) if (p[i]) set_ops(i, rnd_f(), rnd_f());
         req = p[NREQ-1:0];
         k = $countones(req);
         for (int j = 0; j < k; j++) begin
            g = next_grant(req);
            serve(g, r2f(f2r(opa[g]) + f2r(opb[g])), 1'b1, "rnd");
         end
         tick();
      end

      // watchdog: adder never answers
      adder_on = 1'b0;
      lat = 7;
      set_ops(0, int2f(5), int2f(6));
      req = 2'b01;
      wait_start("to");
      k = 0;
      for (int n = 0; n < 100 && done == '0; n++) begin
         tick();
         k++;
      end
      chk("to_cycles", k, TIMEOUT);
      chk("to_done", done, 2'b01);
      chk("to_err", err, 1);
      chk("to_res", res_out, 32'h7FC0_0000);
      rr_ptr = 1;
      req = '0;
      tick();
      chk("to_err_pulse", err, 0);
      adder_on = 1'b1;
      set_ops(0, int2f(-3), int2f(10));
      req = 2'b01;
      g = next_grant(req);
      serve(g, int2f(7), 1'b1, "to_next");

      // reset in the middle of WAIT while requester 1 is served
      lat = 30;
      set_ops(1, int2f(1), int2f(2));
      req = 2'b10;
      wait_start("mr");
      repeat (3) tick();
      rst = 1'b1;
      req = '0;
      tick();
      rst = 1'b0;
      rr_ptr = 0;
      chk("mr_start", add_start, 0);
      chk("mr_busy", busy, 0);
      chk("mr_done", done, 0);
      chk("mr_err", err, 0);
      tick();
      inj_done = 1'b1;
      tick();
      inj_done = 1'b0;
      tick();
      chk("mr_late_done", done, 0);
      chk("mr_late_busy", busy, 0);
      chk("mr_late_err", err, 0);
      lat = 5;
      set_ops(0, int2f(8), int2f(9));
      set_ops(1, int2f(-20), int2f(4));
      req = 2'b11;
      g = next_grant(req);
      serve(g, int2f(17), 1'b1, "mr_first");
      g = next_grant(req);
      serve(g, int2f(-16), 1'b1, "mr_second");

      // operands changing after grant are ignored
      x = rnd_f();
      y = rnd_f();
      set_ops(0, x, y);
      req = 2'b01;
      wait_start("oc");
      a_in[31:0] = x ^ 32'h0040_0000;
      b_in[31:0] = int2f(77);
      tick();
      chk("oc_add_a", add_a, x);
      chk("oc_add_b", add_b, y);
      g = next_grant(req);
      serve(g, r2f(f2r(x) + f2r(y)), 1'b1, "oc");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
Shares one 32-bit floating-point adder (start/done handshake, multi-cycle, one-cycle done pulse) between NREQ requesters. Requesters present operand pairs. The block grants them round-robin, drives the adder operands, and holds the adder start signal until the adder's done pulse. It then returns the sum to the granted requester. A watchdog releases the adder if no done pulse arrives.

Parameters:
NREQ, 2, number of requesters (2..8)
IDXW, 1, index width, must be >= ceil(log2(NREQ))
TIMEOUT, 64, maximum cycles spent in WAIT before abort

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  NREQ  per-requester request; held high with operands until that requester's done
a_in  in  32*NREQ  operand A, requester i on bits [32i+31:32i]
b_in  in  32*NREQ  operand B, same packing
done  out  NREQ  one-cycle pulse to the served requester; res_out valid in that cycle
err  out  1  one-cycle pulse together with done when the operation timed out
res_out  out  32  result word, shared by all requesters
busy  out  1  high whenever state is not IDLE
gnt_idx  out  IDXW  index of the currently served requester
add_a  out  32  adder operand A
add_b  out  32  adder operand B
add_start  out  1  adder request (adder r_i)
add_res  in  32  adder result
add_done  in  1  adder completion pulse (adder r_o)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, done=0, err=0, res_out=0, busy=0, gnt_idx=0, add_a=0, add_b=0, add_start=0, round-robin pointer ptr=0, watchdog counter=0.
- rst has priority over everything. Reset mid-operation aborts at once: no done or err is emitted for the aborted request, and add_start is 0 from the next cycle.
- States:
  - IDLE: if any req bit is set, pick the first set bit at or after ptr, with wrap-around modulo NREQ. Register gnt_idx, register add_a/add_b from that requester's slice, go to ISSUE. Otherwise stay.
  - ISSUE: add_start<=1, watchdog<=0, go to WAIT.
  - WAIT:
    - add_start stays 1 and add_a/add_b stay stable; watchdog increments each cycle.
    - If add_done=1: capture res_out<=add_res, add_start<=0, go to RESP.
    - Else, if watchdog reaches TIMEOUT-1: res_out<=32'h7FC00000 (quiet NaN), err flag set, add_start<=0, go to RESP.
    - If add_done and timeout hit on the same cycle, add_done wins and no error is flagged.
  - RESP:
    - done[gnt_idx]<=1 for exactly one cycle; err<=flag.
    - ptr<=gnt_idx+1, wrapping to 0 at NREQ.
    - Go to IDLE.
- add_start falls on the same edge where add_done is sampled high, so the adder never sees a second request back to back.
- Minimum gap between consecutive grants is one IDLE cycle.
- Controller overhead around the adder latency:
  - 2 cycles from req sampled in IDLE to add_start=1.
  - 1 cycle from add_done to done.
- Operands are sampled only in IDLE at grant time. Changes to a_in/b_in afterwards are ignored.
- A requester that drops req before its done is still served; the done pulse is emitted regardless.
- Fairness: with all requests asserted continuously, each requester is served once per NREQ grants.
- Requests with an out-of-range index (bits beyond NREQ) do not exist; ptr never exceeds NREQ-1.
- res_out holds its value until the next RESP.

Test Plan:
- Single request, NREQ=2, behavioural adder latency 7: req=01, a=0x3F800000, b=0x40000000 -> add_start high 2 cycles after req, drops on add_done; done=01 pulse 1 cycle later; res_out=0x40400000; err=0.
- Mixed sign: requester 1, a=0x40400000, b=0xBF800000 -> done=10, res_out=0x40000000, gnt_idx=1.
- Simultaneous requests: req=11 held, ptr=0 -> served order 0,1,0,1. Each done is a single-cycle pulse; add_start never high for 2 consecutive operations without an intervening low cycle.
- Timeout, TIMEOUT=16, adder model never pulses add_done: req=01 -> done=01 and err=1 exactly 16 cycles after entering WAIT; res_out=0x7FC00000; next request is served normally.
- Reset mid-WAIT: assert rst for 1 cycle while add_start=1 -> next cycle add_start=0, busy=0, ptr=0, no done/err pulse. A late add_done arriving in IDLE is ignored.
- Operand change after grant: change a_in during WAIT -> add_a unchanged; result corresponds to the operands sampled at grant.
